// File: rtl/rv32i_types.sv
// rv32i_types: shared widths, store-width encoding and address helpers
package rv32i_types;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] rv32i_word;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    function automatic rv32i_word word_align(rv32i_word a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// dmem_req_ctrl_if: data-memory request/response bus between MEM stage and memory
interface dmem_req_ctrl_if;
    import rv32i_types::*;

    logic      dmem_read;
    logic      dmem_write;
    rv32i_word dmem_address;
    rv32i_word dmem_wdata;
    logic [3:0] dmem_mbe;
    rv32i_word dmem_rdata;
    logic      dmem_resp;

    modport master (
        output dmem_read,
        output dmem_write,
        output dmem_address,
        output dmem_wdata,
        output dmem_mbe,
        input  dmem_rdata,
        input  dmem_resp
    );

    modport slave (
        input  dmem_read,
        input  dmem_write,
        input  dmem_address,
        input  dmem_wdata,
        input  dmem_mbe,
        output dmem_rdata,
        output dmem_resp
    );

endinterface

// File: rtl/dmem_store_align.sv
// dmem_store_align: byte enables and lane-shifted write data for a store
module dmem_store_align
    import rv32i_types::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] off,
    input  rv32i_word  store_data,
    output logic [3:0] mbe,
    output rv32i_word  wdata
);

    logic [3:0] base;

    // unknown widths act as SW; enables past lane 3 fall off the top
    always_comb begin
        base  = (store_funct3_t'(funct3) == SB) ? 4'b0001 :
                (store_funct3_t'(funct3) == SH) ? 4'b0011 : 4'b1111;
        mbe   = base << off;
        wdata = store_data << {off, 3'b000};
    end

endmodule

// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: MEM-stage data-memory initiator with stall and result capture
module dmem_req_ctrl
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  rv32i_word             addr,
    input  rv32i_word             store_data,
    input  logic                  advance,
    output logic                  stall,
    output rv32i_word             rdata_out,
    output logic [1:0]            bit_shift_out,
    output rv32i_word             orig_addr_out,
    dmem_req_ctrl_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } dmem_state_t;

    dmem_state_t state;
    logic        req;
    logic [3:0]  st_mbe;
    rv32i_word   st_wdata;

    assign req = mem_read | mem_write;

    dmem_store_align u_align (
        .funct3     (funct3),
        .off        (addr[1:0]),
        .store_data (store_data),
        .mbe        (st_mbe),
        .wdata      (st_wdata)
    );

    // hold the pipeline while a request is about to issue or is outstanding
    always_comb begin
        stall = (state == BUSY) || (state == IDLE && req);
    end

    // request FSM: issue, wait for resp, then wait for the pipeline to move
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            bus.dmem_read    <= 1'b0;
            bus.dmem_write   <= 1'b0;
            bus.dmem_address <= '0;
            bus.dmem_wdata   <= '0;
            bus.dmem_mbe     <= '0;
            rdata_out        <= '0;
            bit_shift_out    <= '0;
            orig_addr_out    <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state            <= BUSY;
                    bus.dmem_write   <= mem_write;
                    bus.dmem_read    <= ~mem_write;
                    bus.dmem_address <= word_align(addr);
                    bus.dmem_wdata   <= mem_write ? st_wdata : '0;
                    bus.dmem_mbe     <= mem_write ? st_mbe : 4'b1111;
                    bit_shift_out    <= addr[1:0];
                    orig_addr_out    <= addr;
                end
                BUSY: if (bus.dmem_resp) begin
                    state          <= DONE;
                    rdata_out      <= bus.dmem_read ? bus.dmem_rdata : rdata_out;
                    bus.dmem_read  <= 1'b0;
                    bus.dmem_write <= 1'b0;
                end
                DONE: if (advance) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb_dmem_req_ctrl: directed and randomized checks against a transaction-level model
module tb_dmem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        advance = 1'b0;
    logic        stall;
    logic [31:0] rdata_out;
    logic [1:0]  bit_shift_out;
    logic [31:0] orig_addr_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    dmem_req_ctrl_if bus ();

    dmem_req_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .addr          (addr),
        .store_data    (store_data),
        .advance       (advance),
        .stall         (stall),
        .rdata_out     (rdata_out),
        .bit_shift_out (bit_shift_out),
        .orig_addr_out (orig_addr_out),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // model: one access in flight or finished, expected bus/result values
    logic        m_busy = 1'b0, m_done = 1'b0, m_st = 1'b0;
    logic        e_rd = 1'b0, e_wr = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0, e_orig = '0;
    logic [3:0]  e_mbe = '0;
    logic [1:0]  e_shift = '0;

    function automatic logic [3:0] model_mbe(logic [2:0] f3, logic [1:0] off);
        int n;
        logic [7:0] t;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        t = 8'(((1 << n) - 1) << off);
        return t[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(logic [31:0] sd, logic [1:0] off);
        logic [63:0] t;
        t = {32'd0, sd} << (8 * int'(off));
        return t[31:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_st <= 0; e_rd <= 0; e_wr <= 0;
            e_addr <= 0; e_wdata <= 0; e_rdata <= 0; e_orig <= 0; e_mbe <= 0; e_shift <= 0;
        end else if (m_busy) begin
            if (bus.dmem_resp) begin
                if (!m_st) e_rdata <= bus.dmem_rdata;
                e_rd <= 0; e_wr <= 0; m_busy <= 0; m_done <= 1;
            end
        end else if (m_done) begin
            if (advance) m_done <= 0;
        end else if (mem_read | mem_write) begin
            m_busy  <= 1;
            m_st    <= mem_write;
            e_rd    <= !mem_write;
            e_wr    <= mem_write;
            e_addr  <= addr & 32'hFFFF_FFFC;
            e_mbe   <= mem_write ? model_mbe(funct3, addr[1:0]) : 4'hF;
            e_wdata <= mem_write ? model_wdata(store_data, addr[1:0]) : 32'd0;
            e_shift <= addr[1:0];
            e_orig  <= addr;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dmem_read", 32'(bus.dmem_read), 32'(e_rd));
            chk("dmem_write", 32'(bus.dmem_write), 32'(e_wr));
            chk("dmem_address", bus.dmem_address, e_addr);
            chk("dmem_wdata", bus.dmem_wdata, e_wdata);
            chk("dmem_mbe", 32'(bus.dmem_mbe), 32'(e_mbe));
            chk("stall", 32'(stall), 32'(m_busy | (!m_done & (mem_read | mem_write))));
            chk("rdata_out", rdata_out, e_rdata);
            chk("bit_shift_out", 32'(bit_shift_out), 32'(e_shift));
            chk("orig_addr_out", orig_addr_out, e_orig);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic release_mem();
        mem_read = 0; mem_write = 0; advance = 1;
        nxt();
        advance = 0;
    endtask

    // one access with resp during cycle N+lat; counts stall/strobe cycles
    task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdt,
                        input int lat, output int sc, output int rc, output int wc,
                        output logic [3:0] mbe, output logic [31:0] wd, output logic [31:0] ad);
        sc = 0; rc = 0; wc = 0; mbe = 0; wd = 0; ad = 0;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        advance = 0; bus.dmem_resp = 0;
        for (int i = 0; i <= lat + 2; i++) begin
            @(negedge clk);
            sc += int'(stall); rc += int'(bus.dmem_read); wc += int'(bus.dmem_write);
            if (i == 1) begin
                mbe = bus.dmem_mbe; wd = bus.dmem_wdata; ad = bus.dmem_address;
            end
            nxt();
            bus.dmem_resp  = (i == lat - 1);
            bus.dmem_rdata = (i == lat - 1) ? rdt : $urandom;
        end
    endtask

    int sc, rc, wc;
    logic [3:0] mbe;
    logic [31:0] wd, ad;

    initial begin
        bus.dmem_resp = 0;
        bus.dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("reset_read", 32'(bus.dmem_read), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_rdata", rdata_out, 32'd0);
        nxt();

        xact(1, 0, 3'd2, 32'h1000_0008, 0, 32'hDEAD_BEEF, 3, sc, rc, wc, mbe, wd, ad);
        chk("lw_read_cycles", 32'(rc), 32'd3);
        chk("lw_stall_cycles", 32'(sc), 32'd4);
        chk("lw_address", ad, 32'h1000_0008);
        chk("lw_rdata", rdata_out, 32'hDEAD_BEEF);
        chk("lw_shift", 32'(bit_shift_out), 32'd0);
        release_mem();

        xact(0, 1, 3'd0, 32'h2003, 32'hAB, 0, 1, sc, rc, wc, mbe, wd, ad);
        chk("sb_stall_cycles", 32'(sc), 32'd2);
        chk("sb_mbe", 32'(mbe), 32'h8);
        chk("sb_wdata", wd, 32'hAB00_0000);
        chk("sb_address", ad, 32'h2000);
        chk("sb_rdata_kept", rdata_out, 32'hDEAD_BEEF);
        release_mem();

        xact(0, 1, 3'd1, 32'h402, 32'h1234, 0, 1, sc, rc, wc, mbe, wd, ad);
        chk("sh2_mbe", 32'(mbe), 32'hC);
        chk("sh2_wdata", wd, 32'h1234_0000);
        release_mem();
        xact(0, 1, 3'd1, 32'h403, 32'h1234, 0, 2, sc, rc, wc, mbe, wd, ad);
        chk("sh3_mbe", 32'(mbe), 32'h8);
        chk("sh3_wdata", wd, 32'h3400_0000);
        release_mem();

        xact(1, 0, 3'd2, 32'h100, 0, 32'h77, 1, sc, rc, wc, mbe, wd, ad);
        sc = 0; rc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sc += int'(stall); rc += int'(bus.dmem_read);
            nxt();
        end
        chk("hold_no_reissue", 32'(rc), 32'd0);
        chk("hold_no_stall", 32'(sc), 32'd0);
        chk("hold_rdata", rdata_out, 32'h77);
        advance = 1;
        nxt();
        advance = 0; addr = 32'h300;
        @(negedge clk);
        chk("next_load_stall", 32'(stall), 32'd1);
        nxt();
        @(negedge clk);
        chk("next_load_read", 32'(bus.dmem_read), 32'd1);
        chk("next_load_addr", bus.dmem_address, 32'h300);
        nxt();
        bus.dmem_resp = 1;
        nxt();
        bus.dmem_resp = 0;
        release_mem();

        mem_read = 1; addr = 32'h504;
        nxt();
        rst = 1; mem_read = 0;
        @(negedge clk);
        chk("pre_rst_read", 32'(bus.dmem_read), 32'd1);
        nxt();
        rst = 0; bus.dmem_resp = 1; bus.dmem_rdata = 32'h5555;
        @(negedge clk);
        chk("rst_read", 32'(bus.dmem_read), 32'd0);
        chk("rst_address", bus.dmem_address, 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_orig", orig_addr_out, 32'd0);
        nxt();
        bus.dmem_resp = 0;
        @(negedge clk);
        chk("stray_resp_rdata", rdata_out, 32'd0);
        chk("stray_resp_stall", 32'(stall), 32'd0);
        nxt();

        xact(1, 1, 3'd2, 32'h40, 32'hCAFE_F00D, 0, 1, sc, rc, wc, mbe, wd, ad);
        chk("both_read_cycles", 32'(rc), 32'd0);
        chk("both_write_cycles", 32'(wc), 32'd1);
        chk("both_mbe", 32'(mbe), 32'hF);
        release_mem();

        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            mem_read       = ($urandom_range(0, 2) == 0);
            mem_write      = ($urandom_range(0, 2) == 0);
            funct3         = 3'($urandom_range(0, 7));
            addr           = $urandom;
            store_data     = $urandom;
            advance        = ($urandom_range(0, 2) == 0);
            bus.dmem_resp  = ($urandom_range(0, 2) == 0);
            bus.dmem_rdata = $urandom;
            nxt();
        end
        rst = 0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
